// File: rtl/spi_engine_sdo_lane_scheduler_if.sv
// SDO lane scheduler bus: FIFO-side word stream in, assembled multi-lane word out.
// The master modport is the scheduler; the slave modport is its environment.
interface spi_engine_sdo_lane_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_OF_SDO = 4
);
  logic                             s_data_valid;
  logic                             s_data_ready;
  logic [DATA_WIDTH-1:0]            s_data;
  logic                             s_last;
  logic                             m_valid;
  logic                             m_ready;
  logic [NUM_OF_SDO*DATA_WIDTH-1:0] m_data;

  modport master (
    input  s_data_valid, s_data, m_ready,
    output s_data_ready, s_last, m_valid, m_data
  );

  modport slave (
    output s_data_valid, s_data, m_ready,
    input  s_data_ready, s_last, m_valid, m_data
  );
endinterface

// File: rtl/spi_engine_sdo_lane_scheduler.sv
// Gathers one FIFO word per active SDO lane into its physical lane slot and
// presents the assembled multi-lane word to the output shift register.
module spi_engine_sdo_lane_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_OF_SDO = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   lane_mask_wr,
  input  logic [7:0]                             lane_mask_in,
  input  logic [7:0]                             left_shift,
  input  logic                                   idle_state,
  spi_engine_sdo_lane_scheduler_if.master        bus,
  output logic [3:0]                             active_lanes,
  output logic                                   busy
);
  localparam int LANE_W = (NUM_OF_SDO > 1) ? $clog2(NUM_OF_SDO) : 1;
  localparam int WORD_W = NUM_OF_SDO * DATA_WIDTH;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_OF_SDO - 1);

  typedef enum logic [1:0] {SCAN, COLLECT, PRESENT} state_t;

  state_t                state_q, state_d;
  logic [NUM_OF_SDO-1:0] mask_q, mask_d;
  logic [LANE_W-1:0]     scan_idx_q, scan_idx_d;
  logic [3:0]            scan_cnt_q, scan_cnt_d;
  logic [3:0]            active_lanes_q, active_lanes_d;
  logic [3:0]            k_q, k_d;
  logic [LANE_W-1:0]     list_q [NUM_OF_SDO];
  logic [LANE_W-1:0]     list_d [NUM_OF_SDO];
  logic [WORD_W-1:0]     m_data_q, m_data_d;

  logic [NUM_OF_SDO-1:0] mask_eff;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  ready;
  logic                  last;
  logic                  beat;
  logic                  mask_in_unused;

  assign mask_in_unused = ^lane_mask_in;

  // An all-zero mask means every lane is active.
  assign mask_eff = (lane_mask_in[NUM_OF_SDO-1:0] == '0) ? '1 : lane_mask_in[NUM_OF_SDO-1:0];
  assign shifted  = (left_shift >= 8'(DATA_WIDTH)) ? '0 : (bus.s_data << left_shift);
  assign ready    = (state_q == COLLECT);
  assign last     = ready && (k_q == (active_lanes_q - 4'd1));
  assign beat     = ready && bus.s_data_valid;

  always_comb begin
    state_d        = state_q;
    mask_d         = mask_q;
    scan_idx_d     = scan_idx_q;
    scan_cnt_d     = scan_cnt_q;
    active_lanes_d = active_lanes_q;
    k_d            = k_q;
    list_d         = list_q;
    m_data_d       = m_data_q;

    case (state_q)
      SCAN: begin
        if (mask_q[scan_idx_q]) begin
          list_d[scan_cnt_q[LANE_W-1:0]] = scan_idx_q;
          scan_cnt_d = scan_cnt_q + 4'd1;
        end
        if (scan_idx_q == LAST_LANE) begin
          active_lanes_d = scan_cnt_q + {3'b000, mask_q[scan_idx_q]};
          scan_idx_d     = '0;
          k_d            = '0;
          m_data_d       = {WORD_W{idle_state}};
          state_d        = COLLECT;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      COLLECT: begin
        if (beat) begin
          m_data_d[int'(list_q[k_q[LANE_W-1:0]]) * DATA_WIDTH +: DATA_WIDTH] = shifted;
          k_d = k_q + 4'd1;
          if (last) begin
            state_d = PRESENT;
          end
        end
      end
      PRESENT: begin
        if (bus.m_ready) begin
          k_d      = '0;
          m_data_d = {WORD_W{idle_state}};
          state_d  = COLLECT;
        end
      end
      default: state_d = SCAN;
    endcase

    // A mask load overrides everything, including a beat accepted this cycle.
    if (lane_mask_wr) begin
      mask_d     = mask_eff;
      scan_idx_d = '0;
      scan_cnt_d = '0;
      k_d        = '0;
      state_d    = SCAN;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= SCAN;
      mask_q         <= '1;
      scan_idx_q     <= '0;
      scan_cnt_q     <= '0;
      active_lanes_q <= 4'(NUM_OF_SDO);
      k_q            <= '0;
      list_q         <= '{default: '0};
      m_data_q       <= '0;
    end else begin
      state_q        <= state_d;
      mask_q         <= mask_d;
      scan_idx_q     <= scan_idx_d;
      scan_cnt_q     <= scan_cnt_d;
      active_lanes_q <= active_lanes_d;
      k_q            <= k_d;
      list_q         <= list_d;
      m_data_q       <= m_data_d;
    end
  end

  assign bus.s_data_ready = ready;
  assign bus.s_last       = last;
  assign bus.m_valid      = (state_q == PRESENT);
  assign bus.m_data       = m_data_q;
  assign active_lanes     = active_lanes_q;
  assign busy             = (state_q == SCAN);
endmodule

// File: tb/tb_spi_engine_sdo_lane_scheduler.sv
// Randomized self-checking bench for the SDO lane scheduler, checked against a
// lane-list / slot-array model of the scheduling rules.
module tb_spi_engine_sdo_lane_scheduler;
  localparam int DW = 8;
  localparam int NL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       lane_mask_wr;
  logic [7:0] lane_mask_in;
  logic [7:0] left_shift;
  logic       idle_state;
  logic [3:0] active_lanes;
  logic       busy;

  spi_engine_sdo_lane_scheduler_if #(.DATA_WIDTH(DW), .NUM_OF_SDO(NL)) bus ();

  spi_engine_sdo_lane_scheduler #(.DATA_WIDTH(DW), .NUM_OF_SDO(NL)) dut (
    .clk          (clk),
    .reset        (reset),
    .lane_mask_wr (lane_mask_wr),
    .lane_mask_in (lane_mask_in),
    .left_shift   (left_shift),
    .idle_state   (idle_state),
    .bus          (bus),
    .active_lanes (active_lanes),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: ordered list of active lanes, the slot contents, beats taken so far.
  int            model_list[$];
  logic [DW-1:0] model_slots [NL];
  int            model_k;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] expectedWord();
    logic [63:0] w = '0;
    for (int n = 0; n < NL; n++) w = w | (64'(model_slots[n]) << (n * DW));
    return w;
  endfunction

  task automatic modelSetMask(input logic [7:0] m);
    logic [NL-1:0] eff;
    eff = m[NL-1:0];
    if (eff == '0) eff = '1;
    model_list.delete();
    for (int n = 0; n < NL; n++) if (eff[n]) model_list.push_back(n);
  endtask

  task automatic modelRefill(input logic idle);
    for (int n = 0; n < NL; n++) model_slots[n] = idle ? '1 : '0;
    model_k = 0;
  endtask

  // Scan lasts NL cycles, then ready rises with all slots at the idle level.
  task automatic scanPhase(input logic idle);
    for (int i = 0; i < NL; i++) begin
      checkOutput("scan_busy", busy, 1);
      checkOutput("scan_ready", bus.s_data_ready, 0);
      checkOutput("scan_valid", bus.m_valid, 0);
      tick();
    end
    modelRefill(idle);
    checkOutput("scan_done_busy", busy, 0);
    checkOutput("scan_done_ready", bus.s_data_ready, 1);
    checkOutput("active_lanes", active_lanes, 64'(model_list.size()));
    checkOutput("refill_data", bus.m_data, expectedWord());
  endtask

  task automatic loadMask(input logic [7:0] m, input logic idle);
    idle_state   = idle;
    lane_mask_in = m;
    lane_mask_wr = 1'b1;
    tick();
    lane_mask_wr = 1'b0;
    modelSetMask(m);
    scanPhase(idle);
  endtask

  task automatic sendBeat(input logic [DW-1:0] d, input logic [7:0] ls, input int gap);
    longint v;
    for (int g = 0; g < gap; g++) begin
      bus.s_data_valid = 1'b0;
      checkOutput("gap_s_last", bus.s_last, 64'(model_k == model_list.size() - 1));
      tick();
    end
    bus.s_data_valid = 1'b1;
    bus.s_data       = d;
    left_shift       = ls;
    checkOutput("beat_ready", bus.s_data_ready, 1);
    checkOutput("beat_s_last", bus.s_last, 64'(model_k == model_list.size() - 1));
    idle_state = 1'($urandom);
    tick();
    bus.s_data_valid = 1'b0;
    if (int'(ls) >= DW) v = 0;
    else v = (longint'(d) * (longint'(1) << ls)) % (longint'(1) << DW);
    model_slots[model_list[model_k]] = DW'(v);
    model_k++;
  endtask

  task automatic finishWord();
    checkOutput("word_valid", bus.m_valid, 1);
    checkOutput("word_data", bus.m_data, expectedWord());
    checkOutput("word_ready", bus.s_data_ready, 0);
  endtask

  task automatic presentWord(input int hold, input logic next_idle);
    bus.m_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      checkOutput("hold_valid", bus.m_valid, 1);
      checkOutput("hold_ready", bus.s_data_ready, 0);
      checkOutput("hold_s_last", bus.s_last, 0);
      checkOutput("hold_data", bus.m_data, expectedWord());
      tick();
    end
    idle_state  = next_idle;
    bus.m_ready = 1'b1;
    checkOutput("handoff_valid", bus.m_valid, 1);
    tick();
    bus.m_ready = 1'b0;
    modelRefill(next_idle);
    checkOutput("after_handoff_valid", bus.m_valid, 0);
    checkOutput("after_handoff_ready", bus.s_data_ready, 1);
    checkOutput("after_handoff_idle", bus.m_data, expectedWord());
  endtask

  function automatic logic [7:0] randShift();
    if ($urandom_range(0, 4) == 0) return 8'($urandom_range(DW, 255));
    return 8'($urandom_range(0, DW - 1));
  endfunction

  task automatic applyStimulus(input int iterations);
    for (int it = 0; it < iterations; it++) begin
      loadMask(8'($urandom_range(0, 15)) | (8'($urandom) & 8'hF0), 1'($urandom));
      for (int w = 0; w < int'($urandom_range(1, 3)); w++) begin
        for (int b = 0; b < model_list.size(); b++)
          sendBeat(DW'($urandom), randShift(), $urandom_range(0, 2));
        finishWord();
        presentWord($urandom_range(0, 3), 1'($urandom));
      end
      if (model_list.size() > 1 && $urandom_range(0, 2) == 0) begin
        for (int b = 0; b < int'($urandom_range(1, model_list.size() - 1)); b++)
          sendBeat(DW'($urandom), randShift(), 0);
        checkOutput("partial_no_valid", bus.m_valid, 0);
      end
    end
  endtask

  initial begin
    reset            = 1'b1;
    lane_mask_wr     = 1'b0;
    lane_mask_in     = '0;
    left_shift       = '0;
    idle_state       = 1'b0;
    bus.s_data_valid = 1'b0;
    bus.s_data       = '0;
    bus.m_ready      = 1'b0;
    model_k          = 0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_ready", bus.s_data_ready, 0);
    checkOutput("rst_valid", bus.m_valid, 0);
    checkOutput("rst_data", bus.m_data, 0);
    checkOutput("rst_busy", busy, 1);
    checkOutput("rst_active", active_lanes, NL);
    checkOutput("rst_s_last", bus.s_last, 0);
    reset = 1'b0;
    modelSetMask(8'h00);
    scanPhase(1'b0);

    // All lanes, plain data.
    sendBeat(8'h11, 8'd0, 0);
    sendBeat(8'h22, 8'd0, 0);
    sendBeat(8'h33, 8'd0, 0);
    sendBeat(8'h44, 8'd0, 0);
    finishWord();
    checkOutput("tp_all_lanes", bus.m_data, 64'h44332211);
    presentWord(0, 1'b0);

    // Sparse mask with idle-high fill, then a long backpressure hold.
    loadMask(8'b1010, 1'b1);
    checkOutput("tp_sparse_active", active_lanes, 2);
    sendBeat(8'hA1, 8'd0, 0);
    sendBeat(8'hB2, 8'd0, 0);
    finishWord();
    checkOutput("tp_sparse_word", bus.m_data, 64'hB2FFA1FF);
    presentWord(5, 1'b0);
    checkOutput("tp_handoff_idle", bus.m_data, 64'h0);

    // Alignment shifts, including a shift equal to the word width.
    loadMask(8'b0001, 1'b0);
    sendBeat(8'h1F, 8'd3, 0);
    finishWord();
    checkOutput("tp_shift3", bus.m_data, 64'h000000F8);
    presentWord(0, 1'b0);
    sendBeat(8'h1F, 8'd8, 0);
    finishWord();
    checkOutput("tp_shift8", bus.m_data, 64'h0);
    presentWord(0, 1'b0);

    // Mask change mid-word, with a beat handshaking in the same cycle.
    loadMask(8'b1111, 1'b0);
    sendBeat(8'hC1, 8'd0, 0);
    sendBeat(8'hC2, 8'd0, 0);
    idle_state       = 1'b0;
    bus.s_data_valid = 1'b1;
    bus.s_data       = 8'hEE;
    lane_mask_in     = 8'b0100;
    lane_mask_wr     = 1'b1;
    checkOutput("tp_abort_ready", bus.s_data_ready, 1);
    tick();
    lane_mask_wr     = 1'b0;
    bus.s_data_valid = 1'b0;
    modelSetMask(8'b0100);
    scanPhase(1'b0);
    sendBeat(8'h5A, 8'd0, 0);
    finishWord();
    checkOutput("tp_abort_word", bus.m_data, 64'h005A0000);
    presentWord(1, 1'b0);

    // Zero mask means all lanes; then asynchronous reset while presenting.
    loadMask(8'h00, 1'b0);
    checkOutput("tp_zero_mask", active_lanes, 4);
    for (int b = 0; b < NL; b++) sendBeat(DW'($urandom), 8'd0, 0);
    finishWord();
    #2 reset = 1'b1;
    #1;
    checkOutput("async_rst_valid", bus.m_valid, 0);
    checkOutput("async_rst_data", bus.m_data, 0);
    checkOutput("async_rst_busy", busy, 1);
    idle_state = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    modelSetMask(8'h00);
    scanPhase(1'b0);

    applyStimulus(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
